zone_accum_ctrl: RTL and testbench
==================================

# zone_accum_ctrl

Frame-level controller that sequences the LED mean-colour datapath. It consumes an RGB444 pixel stream and accumulates per-zone channel sums over a 4x4 zone grid (16 zones). At the end of each complete frame it presents the 16 sums per channel, stable, together with a one-cycle start pulse. The mean-computation stage downstream takes those sums and the pulse directly.

## Interface
- H_ACT, 364, active pixels per line; multiple of 4; zone width ZW = H_ACT/4
- V_ACT, 320, active lines per frame; multiple of 4; zone height ZH = V_ACT/4
- SUM_W, 17, width of each zone sum
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- enable_i  in  1  permits a new frame to start
- pix_valid_i  in  1  pixel qualifier
- pix_sof_i  in  1  first pixel of frame; meaningful only with pix_valid_i
- pix_r_i, pix_g_i, pix_b_i  in  4 each  pixel channels
- SumR, SumG, SumB  out  [SUM_W-1:0] x16 each  zone sums; zone index z = zy*4 + zx
- start_o  out  1  one-cycle pulse; sums are final and stable in that cycle
- busy_o  out  1  frame accumulation in progress
- frame_err_o  out  1  sticky; set on a premature sof, cleared only by reset
- frame_cnt_o  out  8  completed frames, wraps 255 -> 0

## Operation
- Reset values: all Sum* = 0, start_o = 0, busy_o = 0, frame_err_o = 0, frame_cnt_o = 0, state IDLE.
- States:
  - IDLE: no frame yet since reset.
  - ACCUM: a frame is being accumulated.
  - HOLD: frame complete; sums frozen.
- Start condition, in IDLE or HOLD: accepted pixel (pix_valid_i & pix_sof_i & enable_i).
  - Zone 0 sums load that pixel's values; all other sums load 0.
  - x = 1, y = 0; go to ACCUM.
- In IDLE or HOLD, all other pixels are ignored. Sums do not change.
- ACCUM, on each valid pixel without sof:
  - Add the pixel to zone (zx, zy), where zx = x / ZW and zy = y / ZH.
  - zx and zy come from sub-counters that wrap at ZW and ZH. No divider.
  - x increments. At x = H_ACT-1 it wraps to 0 and y increments.
- Frame completion: accepted pixel at x = H_ACT-1, y = V_ACT-1.
  - Go to HOLD.
  - start_o = 1 on the next cycle.
  - frame_cnt_o increments.
- Sof during ACCUM:
  - frame_err_o sets.
  - The current frame is discarded, with no start_o.
  - The restart action is taken immediately with that pixel, gated by enable_i. If enable_i = 0, go to IDLE with sums cleared to 0.
- enable_i deasserted during ACCUM: the frame still completes normally. Only new starts are blocked.
- Additions saturate at 2^SUM_W - 1 per sum.
  - With default parameters the maximum is 7280*15 = 109200, which does not saturate.
- busy_o = (state == ACCUM), registered.

## Timing
- Every output is a flop.
- Pixel accepted at edge N: its contribution is visible in Sum* after edge N.
- Last pixel accepted at edge N:
  - start_o is high for exactly one cycle, between edges N and N+1.
  - busy_o falls after edge N.
  - frame_cnt_o updates after edge N.
- Sums hold from completion until the edge that accepts the next sof.
  - Downstream may sample them in the start_o cycle or any later HOLD cycle.
- Gaps in pix_valid_i are allowed anywhere. Counters and sums hold while pix_valid_i = 0.
- Back-to-back frames are supported: a sof on the cycle after the last pixel, while start_o = 1, is accepted. Sums change only after that edge, so the start_o cycle still shows the final sums.
- Reset mid-frame: immediate return to reset values. No start_o is produced.

## Test plan
1. Constant frame r=15, g=8, b=0, default parameters, pix_valid_i continuously high.
   - start_o one cycle after the last pixel.
   - Every SumR = 109200, SumG = 58240, SumB = 0.
   - frame_cnt_o = 1; busy_o low afterwards.
2. Zone mapping: r=1 only for x in 91..181 and y in 80..159, all else 0.
   - SumR[5] = 7280; all other SumR = 0.
   - Repeat the check for each of the 16 zones.
3. Random 50% pix_valid_i gaps on the scenario 1 frame.
   - Identical sums.
   - start_o exactly one cycle after the final valid pixel.
4. Sof injected at pixel 1000 of a frame, followed by a full constant frame r=3.
   - frame_err_o = 1; no start_o for the aborted frame.
   - Next start_o shows all SumR = 21840.
5. Saturation and controls: H_ACT = V_ACT = 8, SUM_W = 5, all channels 15.
   - Each sum = 31 (60 saturated).
   - enable_i low at sof: no start, sums stay at their previous values.
   - rst_n pulse mid-frame: all outputs return to reset values.
6. Back-to-back frames with sof on the start_o cycle.
   - Both frames produce start_o.
   - frame_cnt_o increments twice.
   - Wrap from 255 to 0 checked over 256 small frames.

Source files
------------

// File: rtl/zone_accum_ctrl_if.sv
// Pixel stream bundle feeding the zone accumulator.
// The source drives it (master); the controller samples it (slave).
interface zone_accum_ctrl_if;
   logic       pix_valid_i;
   logic       pix_sof_i;
   logic [3:0] pix_r_i;
   logic [3:0] pix_g_i;
   logic [3:0] pix_b_i;

   modport master (
      output pix_valid_i, pix_sof_i,
      output pix_r_i, pix_g_i, pix_b_i
   );

   modport slave (
      input pix_valid_i, pix_sof_i,
      input pix_r_i, pix_g_i, pix_b_i
   );
endinterface

// File: rtl/zone_accum_ctrl.sv
// Frame sequencer: accumulates RGB444 pixels into 4x4 zone sums
// and hands them to the mean stage with a one-cycle start pulse.
module zone_accum_ctrl #(
   parameter int H_ACT = 364,
   parameter int V_ACT = 320,
   parameter int SUM_W = 17
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable_i,
   zone_accum_ctrl_if.slave pix,
   output logic [SUM_W-1:0] SumR [16],
   output logic [SUM_W-1:0] SumG [16],
   output logic [SUM_W-1:0] SumB [16],
   output logic             start_o,
   output logic             busy_o,
   output logic             frame_err_o,
   output logic [7:0]       frame_cnt_o
);

   localparam int ZW  = H_ACT / 4;
   localparam int ZH  = V_ACT / 4;
   localparam int XW  = $clog2(H_ACT);
   localparam int YW  = $clog2(V_ACT);
   localparam int CXW = $clog2(ZW + 1);
   localparam int CYW = $clog2(ZH + 1);

   localparam logic [XW-1:0]  X_LAST  = XW'(H_ACT - 1);
   localparam logic [YW-1:0]  Y_LAST  = YW'(V_ACT - 1);
   localparam logic [CXW-1:0] CX_LAST = CXW'(ZW - 1);
   localparam logic [CYW-1:0] CY_LAST = CYW'(ZH - 1);

   // The sof pixel occupies x = 0, so counters restart one step in.
   localparam logic [CXW-1:0] CX_START = (ZW == 1) ? '0 : CXW'(1);
   localparam logic [1:0]     ZX_START = (ZW == 1) ? 2'd1 : 2'd0;

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   state_t         state;
   logic [XW-1:0]  x;
   logic [YW-1:0]  y;
   logic [CXW-1:0] cx;
   logic [CYW-1:0] cy;
   logic [1:0]     zx;
   logic [1:0]     zy;

   logic       sof_ok;
   logic       abort;
   logic       acc;
   logic       last;
   logic [3:0] zi;

   always_comb begin
      sof_ok = pix.pix_valid_i & pix.pix_sof_i & enable_i;
      abort  = pix.pix_valid_i & pix.pix_sof_i & (state == ACCUM);
      acc    = pix.pix_valid_i & ~pix.pix_sof_i & (state == ACCUM);
      last   = acc & (x == X_LAST) & (y == Y_LAST);
      zi     = {zy, zx};
   end

   function automatic logic [SUM_W-1:0] sat_add(
      input logic [SUM_W-1:0] s,
      input logic [3:0]       p
   );
      logic [SUM_W:0] t;
      t = {1'b0, s} + (SUM_W+1)'(p);
      return t[SUM_W] ? '1 : t[SUM_W-1:0];
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         x           <= '0;
         y           <= '0;
         cx          <= '0;
         cy          <= '0;
         zx          <= '0;
         zy          <= '0;
         start_o     <= 1'b0;
         busy_o      <= 1'b0;
         frame_err_o <= 1'b0;
         frame_cnt_o <= '0;
         for (int i = 0; i < 16; i++) begin
            SumR[i] <= '0;
            SumG[i] <= '0;
            SumB[i] <= '0;
         end
      end else begin
         start_o <= last;
         unique case (1'b1)
            (sof_ok | abort): begin
               if (abort) frame_err_o <= 1'b1;
               for (int i = 0; i < 16; i++) begin
                  SumR[i] <= '0;
                  SumG[i] <= '0;
                  SumB[i] <= '0;
               end
               if (sof_ok) begin
                  SumR[0] <= SUM_W'(pix.pix_r_i);
                  SumG[0] <= SUM_W'(pix.pix_g_i);
                  SumB[0] <= SUM_W'(pix.pix_b_i);
               end
               x      <= XW'(1);
               cx     <= CX_START;
               zx     <= ZX_START;
               y      <= '0;
               cy     <= '0;
               zy     <= '0;
               state  <= sof_ok ? ACCUM : IDLE;
               busy_o <= sof_ok;
            end
            acc: begin
               SumR[zi] <= sat_add(SumR[zi], pix.pix_r_i);
               SumG[zi] <= sat_add(SumG[zi], pix.pix_g_i);
               SumB[zi] <= sat_add(SumB[zi], pix.pix_b_i);
               if (x == X_LAST) begin
                  x  <= '0;
                  cx <= '0;
                  zx <= '0;
                  y  <= (y == Y_LAST) ? '0 : y + YW'(1);
                  if (cy == CY_LAST) begin
                     cy <= '0;
                     zy <= zy + 2'd1;
                  end else begin
                     cy <= cy + CYW'(1);
                  end
               end else begin
                  x <= x + XW'(1);
                  if (cx == CX_LAST) begin
                     cx <= '0;
                     zx <= zx + 2'd1;
                  end else begin
                     cx <= cx + CXW'(1);
                  end
               end
               if (last) begin
                  state       <= HOLD;
                  busy_o      <= 1'b0;
                  frame_cnt_o <= frame_cnt_o + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_zone_accum_ctrl.sv
// Scoreboard bench for zone_accum_ctrl on a 12x8 frame with 5-bit sums;
// each zone is 3x2 pixels, so a constant channel c sums to min(6c, 31).
module tb_zone_accum_ctrl;

   localparam int H    = 12;
   localparam int V    = 8;
   localparam int SW   = 5;
   localparam int ZW   = H / 4;
   localparam int ZH   = V / 4;
   localparam int NPIX = H * V;

   typedef struct packed {
      logic [15:0][4:0] r;
      logic [15:0][4:0] g;
      logic [15:0][4:0] b;
      logic [7:0]       cnt;
      int               cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic enable_i;
   logic [SW-1:0] sum_r [16];
   logic [SW-1:0] sum_g [16];
   logic [SW-1:0] sum_b [16];
   logic start_o;
   logic busy_o;
   logic frame_err_o;
   logic [7:0] frame_cnt_o;

   logic [15:0][4:0] act_r;
   logic [15:0][4:0] act_g;
   logic [15:0][4:0] act_b;

   zone_accum_ctrl_if pif ();

   zone_accum_ctrl #(.H_ACT(H), .V_ACT(V), .SUM_W(SW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable_i    (enable_i),
      .pix         (pif),
      .SumR        (sum_r),
      .SumG        (sum_g),
      .SumB        (sum_b),
      .start_o     (start_o),
      .busy_o      (busy_o),
      .frame_err_o (frame_err_o),
      .frame_cnt_o (frame_cnt_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      for (int i = 0; i < 16; i++) begin
         act_r[i] = sum_r[i];
         act_g[i] = sum_g[i];
         act_b[i] = sum_b[i];
      end
   end

   int   n_tests = 0;
   int   n_fail  = 0;
   int   exp_cnt = 0;
   exp_t sb [$];
   exp_t mon_e;

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chkv(input string nm, input logic [79:0] act,
                       input logic [79:0] exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [79:0] rep(input int v);
      logic [15:0][4:0] t;
      for (int i = 0; i < 16; i++) t[i] = 5'(v);
      return t;
   endfunction

   task automatic push_exp(input int er, input int eg, input int eb,
                           input int zone, input int ecyc);
      exp_t e;
      for (int z = 0; z < 16; z++) begin
         e.r[z] = (zone < 0 || zone == z) ? 5'(er) : 5'd0;
         e.g[z] = (zone < 0 || zone == z) ? 5'(eg) : 5'd0;
         e.b[z] = (zone < 0 || zone == z) ? 5'(eb) : 5'd0;
      end
      exp_cnt++;
      e.cnt = 8'(exp_cnt);
      e.cyc = ecyc;
      sb.push_back(e);
   endtask

   // Monitor: every start pulse must match the oldest expected frame.
   always @(negedge clk) begin
      if (start_o) begin
         if (sb.size() == 0) begin
            chk("unexpected_start", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            chk("start_cycle", cyc, mon_e.cyc);
            chk("frame_cnt", int'(frame_cnt_o), int'(mon_e.cnt));
            chkv("sum_r", act_r, mon_e.r);
            chkv("sum_g", act_g, mon_e.g);
            chkv("sum_b", act_b, mon_e.b);
            chk("busy_at_start", int'(busy_o), 0);
         end
      end
   end

   task automatic send_frame(
      input int r, input int g, input int b, input int zone,
      input bit gaps, input int npx, input bit push,
      input int er, input int eg, input int eb,
      input bit b2b, input bit en_drop, input bit exp_busy
   );
      int x, y, z;
      for (int p = 0; p < npx; p++) begin
         while (gaps && $urandom_range(0, 1) == 1) begin
            @(negedge clk);
            pif.pix_valid_i = 1'b0;
         end
         @(negedge clk);
         if (p == npx / 2 && p > 0) chk("busy_mid", int'(busy_o), int'(exp_busy));
         if (en_drop && p == 5) enable_i = 1'b0;
         x = p % H;
         y = p / H;
         z = (y / ZH) * 4 + x / ZW;
         pif.pix_valid_i = 1'b1;
         pif.pix_sof_i   = (p == 0);
         pif.pix_r_i     = (zone < 0 || zone == z) ? 4'(r) : 4'd0;
         pif.pix_g_i     = 4'(g);
         pif.pix_b_i     = 4'(b);
         if (push && p == NPIX - 1) push_exp(er, eg, eb, zone, cyc + 1);
      end
      if (!b2b) begin
         @(negedge clk);
         pif.pix_valid_i = 1'b0;
         pif.pix_sof_i   = 1'b0;
      end
      if (en_drop) enable_i = 1'b1;
   endtask

   initial begin
      rst_n           = 1'b0;
      enable_i        = 1'b1;
      pif.pix_valid_i = 1'b0;
      pif.pix_sof_i   = 1'b0;
      pif.pix_r_i     = '0;
      pif.pix_g_i     = '0;
      pif.pix_b_i     = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_start", int'(start_o), 0);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_err", int'(frame_err_o), 0);
      chk("rst_cnt", int'(frame_cnt_o), 0);
      chkv("rst_sum_r", act_r, rep(0));
      chkv("rst_sum_g", act_g, rep(0));
      chkv("rst_sum_b", act_b, rep(0));

      // Constant frame; red saturates (90 -> 31)
      send_frame(15, 5, 1, -1, 0, NPIX, 1, 31, 30, 6, 0, 0, 1);
      @(negedge clk);
      chk("t1_busy_after", int'(busy_o), 0);
      chk("t1_cnt", int'(frame_cnt_o), 1);

      for (int k = 0; k < 16; k++)
         send_frame(1, 0, 0, k, 0, NPIX, 1, 6, 0, 0, 0, 0, 1);

      // Random valid gaps; green saturates (42 -> 31)
      send_frame(2, 7, 3, -1, 1, NPIX, 1, 12, 31, 18, 0, 0, 1);

      // Premature sof at pixel 40 restarts into a full frame
      send_frame(9, 9, 9, -1, 0, 40, 0, 0, 0, 0, 1, 0, 1);
      send_frame(5, 0, 4, -1, 0, NPIX, 1, 30, 0, 24, 0, 0, 1);
      chk("abort_err", int'(frame_err_o), 1);

      // enable_i low at sof: frame ignored, sums held
      enable_i = 1'b0;
      send_frame(15, 15, 15, -1, 0, NPIX, 0, 0, 0, 0, 0, 0, 0);
      enable_i = 1'b1;
      @(negedge clk);
      chkv("en_low_sum_r", act_r, rep(30));
      chkv("en_low_sum_b", act_b, rep(24));
      chk("en_low_busy", int'(busy_o), 0);
      chk("en_low_cnt", int'(frame_cnt_o), exp_cnt);

      // enable_i dropped mid-frame: frame still completes
      send_frame(4, 4, 4, -1, 0, NPIX, 1, 24, 24, 24, 0, 1, 1);

      // sof with enable_i low while accumulating: back to IDLE, cleared
      send_frame(7, 7, 7, -1, 0, 20, 0, 0, 0, 0, 1, 0, 1);
      @(negedge clk);
      enable_i        = 1'b0;
      pif.pix_valid_i = 1'b1;
      pif.pix_sof_i   = 1'b1;
      @(negedge clk);
      pif.pix_valid_i = 1'b0;
      pif.pix_sof_i   = 1'b0;
      enable_i        = 1'b1;
      chkv("idle_clr_sum_r", act_r, rep(0));
      chkv("idle_clr_sum_g", act_g, rep(0));
      chk("idle_clr_busy", int'(busy_o), 0);
      chk("idle_clr_err", int'(frame_err_o), 1);

      // Reset mid-frame
      send_frame(7, 7, 7, -1, 0, 30, 0, 0, 0, 0, 1, 0, 1);
      @(negedge clk);
      rst_n           = 1'b0;
      pif.pix_valid_i = 1'b0;
      pif.pix_sof_i   = 1'b0;
      #1;
      chk("mid_rst_busy", int'(busy_o), 0);
      chk("mid_rst_err", int'(frame_err_o), 0);
      chk("mid_rst_cnt", int'(frame_cnt_o), 0);
      chk("mid_rst_start", int'(start_o), 0);
      chkv("mid_rst_sum_r", act_r, rep(0));
      exp_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;

      // Back-to-back frames, sof during the start_o cycle
      send_frame(15, 15, 15, -1, 0, NPIX, 1, 31, 31, 31, 1, 0, 1);
      send_frame(1, 2, 3, -1, 0, NPIX, 1, 6, 12, 18, 0, 0, 1);
      @(negedge clk);
      chk("b2b_cnt", int'(frame_cnt_o), 2);

      // 256 more frames: counter wraps through 255 -> 0
      for (int k = 0; k < 256; k++)
         send_frame(1, 1, 1, -1, 0, NPIX, 1, 6, 6, 6, (k != 255), 0, 1);
      repeat (4) @(negedge clk);
      chk("wrap_cnt", int'(frame_cnt_o), 2);
      chk("scoreboard_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
